// File: rtl/env_monitor.sv
// env_monitor: validates DHT11 readings, keeps 4-sample moving averages,
// classifies temperature/humidity into comfort bands with hysteresis.
module env_monitor #(
  parameter int TEMP_HOT     = 30,
  parameter int TEMP_COLD    = 18,
  parameter int HUM_WET      = 70,
  parameter int HUM_DRY      = 30,
  parameter int HYST         = 1,
  parameter int TEMP_MAX     = 60,
  parameter int HUM_MAX      = 100,
  parameter int STALE_CYCLES = 375_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [15:0] hum_in,
  input  logic [15:0] temp_in,
  output logic [7:0]  temp_avg,
  output logic [7:0]  hum_avg,
  output logic [1:0]  temp_state,
  output logic [1:0]  hum_state,
  output logic        stale,
  output logic        update,
  output logic        err_range
);

  localparam int CW = $clog2(STALE_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE, S_CHECK, S_WRITE, S_CLASSIFY
  } state_t;

  state_t r_state, w_next;

  logic          r_valid_q;
  logic [7:0]    r_t, r_h;
  logic [7:0]    r_tring [4];
  logic [7:0]    r_hring [4];
  logic [1:0]    r_ptr;
  logic [9:0]    r_tsum, r_hsum;
  logic          r_fill;
  logic [CW-1:0] r_cnt;

  logic          w_rise;
  logic          w_bad;
  logic [9:0]    w_tsum, w_hsum;
  logic          w_unused;

  assign w_rise   = valid_in & ~r_valid_q;
  assign w_unused = ^{hum_in[7:0], temp_in[7:0]};

  function automatic logic [1:0] band(
    input logic [1:0] s,
    input logic [7:0] a,
    input int         hi,
    input int         lo
  );
    logic [1:0] n;
    int         v;
    v = int'(a);
    n = s;
    case (s)
      2'b00: begin
        if (v >= hi)      n = 2'b10;
        else if (v <= lo) n = 2'b01;
      end
      2'b10: begin
        if (v <= lo)             n = 2'b01;
        else if (v <= hi - HYST) n = 2'b00;
      end
      2'b01: begin
        if (v >= hi)             n = 2'b10;
        else if (v >= lo + HYST) n = 2'b00;
      end
      default: n = 2'b00;
    endcase
    return n;
  endfunction

  always_comb begin
    w_bad = (int'(r_t) > TEMP_MAX) || (int'(r_h) > HUM_MAX);
    // First sample after reset/stale preloads the whole window
    if (r_fill) begin
      w_tsum = r_tsum - {2'b00, r_tring[r_ptr]} + {2'b00, r_t};
      w_hsum = r_hsum - {2'b00, r_hring[r_ptr]} + {2'b00, r_h};
    end else begin
      w_tsum = {r_t, 2'b00};
      w_hsum = {r_h, 2'b00};
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (w_rise) w_next = S_CHECK;
      S_CHECK:    w_next = w_bad ? S_IDLE : S_WRITE;
      S_WRITE:    w_next = S_CLASSIFY;
      S_CLASSIFY: w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid_q  <= 1'b0;
      r_t        <= '0;
      r_h        <= '0;
      r_ptr      <= '0;
      r_tsum     <= '0;
      r_hsum     <= '0;
      r_fill     <= 1'b0;
      r_cnt      <= '0;
      temp_avg   <= '0;
      hum_avg    <= '0;
      temp_state <= 2'b00;
      hum_state  <= 2'b00;
      stale      <= 1'b1;
      update     <= 1'b0;
      err_range  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_tring[i] <= '0;
        r_hring[i] <= '0;
      end
    end else begin
      r_valid_q <= valid_in;
      update    <= 1'b0;
      err_range <= 1'b0;

      if (r_state == S_IDLE && w_rise) begin
        r_t <= temp_in[15:8];
        r_h <= hum_in[15:8];
      end

      if (r_state == S_CHECK && w_bad) err_range <= 1'b1;

      if (r_state == S_WRITE) begin
        r_cnt <= '0;
        stale <= 1'b0;
      end else if (r_cnt != CW'(STALE_CYCLES)) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == CW'(STALE_CYCLES - 1)) begin
          stale  <= 1'b1;
          r_fill <= 1'b0;
        end
      end

      // Averages and bands are registered straight from the new sums
      if (r_state == S_WRITE) begin
        if (r_fill) begin
          r_tring[r_ptr] <= r_t;
          r_hring[r_ptr] <= r_h;
          r_ptr          <= r_ptr + 2'd1;
        end else begin
          for (int i = 0; i < 4; i++) begin
            r_tring[i] <= r_t;
            r_hring[i] <= r_h;
          end
        end
        r_tsum     <= w_tsum;
        r_hsum     <= w_hsum;
        r_fill     <= 1'b1;
        temp_avg   <= w_tsum[9:2];
        hum_avg    <= w_hsum[9:2];
        temp_state <= band(temp_state, w_tsum[9:2], TEMP_HOT, TEMP_COLD);
        hum_state  <= band(hum_state, w_hsum[9:2], HUM_WET, HUM_DRY);
        update     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_env_monitor.sv
// tb_env_monitor: directed test-plan sequences plus randomized samples
// checked against a queue-based moving-average and band model.
module tb_env_monitor;

  localparam int STALE = 1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [15:0] hum_in, temp_in;
  logic [7:0]  temp_avg, hum_avg;
  logic [1:0]  temp_state, hum_state;
  logic        stale, update, err_range;

  always #5 clk = ~clk;

  env_monitor #(.STALE_CYCLES(STALE)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in),
    .hum_in(hum_in), .temp_in(temp_in),
    .temp_avg(temp_avg), .hum_avg(hum_avg),
    .temp_state(temp_state), .hum_state(hum_state),
    .stale(stale), .update(update), .err_range(err_range)
  );

  int checks = 0;
  int fails  = 0;

  int mq_t[$], mq_h[$];
  int m_tavg, m_havg, m_tst, m_hst;
  int since_wr;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int band(int s, int a, int hi, int lo);
    if (s == 0) return (a >= hi) ? 2 : (a <= lo) ? 1 : 0;
    if (s == 2) return (a <= lo) ? 1 : (a <= hi - 1) ? 0 : 2;
    return (a >= hi) ? 2 : (a >= lo + 1) ? 0 : 1;
  endfunction

  function automatic int qavg(int q[$]);
    int s = 0;
    foreach (q[i]) s += q[i];
    return s / 4;
  endfunction

  task automatic model_write(input int t, input int h);
    if (since_wr >= STALE) begin
      mq_t = {t, t, t, t};
      mq_h = {h, h, h, h};
    end else begin
      void'(mq_t.pop_front());
      void'(mq_h.pop_front());
      mq_t.push_back(t);
      mq_h.push_back(h);
    end
    m_tavg = qavg(mq_t);
    m_havg = qavg(mq_h);
    m_tst  = band(m_tst, m_tavg, 30, 18);
    m_hst  = band(m_hst, m_havg, 70, 30);
  endtask

  task automatic model_reset();
    mq_t.delete();
    mq_h.delete();
    m_tavg = 0; m_havg = 0; m_tst = 0; m_hst = 0;
    since_wr = STALE;
  endtask

  task automatic tick(input bit wrote);
    @(negedge clk);
    if (wrote) since_wr = 0;
    else if (since_wr < STALE + 10) since_wr++;
    chk("stale", int'(stale), int'(since_wr >= STALE));
  endtask

  task automatic chk_outs(input string tag);
    chk({tag, "_tavg"}, int'(temp_avg), m_tavg);
    chk({tag, "_havg"}, int'(hum_avg), m_havg);
    chk({tag, "_tst"}, int'(temp_state), m_tst);
    chk({tag, "_hst"}, int'(hum_state), m_hst);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    valid_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic send(input int t, input int h, input int hold);
    bit ok;
    int nu, ne, kmax;
    logic [7:0] t8, h8;
    ok = (t <= 60) && (h <= 100);
    nu = 0; ne = 0;
    kmax = (hold + 5 > 7) ? hold + 5 : 7;
    t8 = 8'(t); h8 = 8'(h);
    temp_in  = {t8, 8'($urandom)};
    hum_in   = {h8, 8'($urandom)};
    valid_in = 1'b1;
    for (int k = 1; k <= kmax; k++) begin
      tick(ok && k == 3);
      if (k == hold) valid_in = 1'b0;
      if (update)    nu++;
      if (err_range) ne++;
      if (k == 2 && !ok) chk("err_T2", int'(err_range), 1);
      if (k == 2 && ok)  model_write(t, h);
      if (k == 3 && ok) begin
        chk("upd_T3", int'(update), 1);
        chk_outs("T3");
      end
    end
    chk("upd_cnt", nu, int'(ok));
    chk("err_cnt", ne, int'(!ok));
    chk_outs("post");
  endtask

  initial begin
    int n;
    hum_in = '0; temp_in = '0;
    do_reset();
    chk("rst_tavg", int'(temp_avg), 0);
    chk("rst_havg", int'(hum_avg), 0);
    chk("rst_tst", int'(temp_state), 0);
    chk("rst_hst", int'(hum_state), 0);
    chk("rst_stale", int'(stale), 1);
    chk("rst_upd", int'(update), 0);
    chk("rst_err", int'(err_range), 0);
    repeat (100) tick(0);
    chk_outs("idle");
    chk("idle_upd", int'(update), 0);

    send(25, 50, 1);
    chk("pre_t", int'(temp_avg), 25);
    chk("pre_h", int'(hum_avg), 50);

    do_reset();
    send(20, 50, 1);
    send(24, 50, 1); chk("avg21", int'(temp_avg), 21);
    send(24, 50, 2); chk("avg22", int'(temp_avg), 22);
    send(24, 50, 1); chk("avg23", int'(temp_avg), 23);
    send(24, 50, 1); chk("avg24", int'(temp_avg), 24);
    send(24, 50, 1); chk("wrap24", int'(temp_avg), 24);

    do_reset();
    send(31, 50, 1); chk("hot0", int'(temp_state), 2);
    send(29, 50, 1); chk("hot1", int'(temp_state), 2);
    send(29, 50, 1); chk("hot2", int'(temp_state), 2);
    send(29, 50, 1); chk("ok29", int'(temp_state), 0);

    do_reset();
    send(25, 35, 1); chk("hok", int'(hum_state), 0);
    send(25, 10, 1); chk("dry28", int'(hum_avg), 28);
    chk("dry_st", int'(hum_state), 1);
    send(25, 10, 1); chk("dry2", int'(hum_state), 1);

    send(61, 50, 1);
    send(25, 101, 1);
    send(60, 100, 10);

    n = 0;
    while (!stale && n < 1200) begin
      tick(0);
      n++;
    end
    chk("stale_len", since_wr, STALE);
    send(40, 50, 1);
    chk("stale_pre", int'(temp_avg), 40);

    temp_in = 16'h3200;
    valid_in = 1'b1;
    tick(0);
    rst = 1'b1;
    valid_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk("mid_tavg", int'(temp_avg), 0);
    chk("mid_stale", int'(stale), 1);
    chk("mid_upd", int'(update), 0);
    repeat (3) tick(0);
    send(33, 80, 1);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 14) == 0)
        repeat ($urandom_range(990, 1010)) tick(0);
      else
        repeat ($urandom_range(0, 20)) tick(0);
      send(int'($urandom_range(0, 70)), int'($urandom_range(0, 110)),
           int'($urandom_range(1, 4)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
